// File: rtl/irrigacao_pkg.sv
// Shared definitions for the irrigation controller: state encodings and default timer width.
package irrigacao_pkg;

  localparam int CONT_W_PADRAO = 16;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    REGANDO = 2'd1,
    PAUSA   = 2'd2,
    ALARME  = 2'd3
  } estado_t;

endpackage

// File: rtl/temporizador.sv
// Loadable down-counter: loads a value, decrements while enabled, saturates at 0.
module temporizador
  import irrigacao_pkg::*;
#(
  parameter int CONT_W = CONT_W_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              carregar,
  input  logic [CONT_W-1:0] valor,
  input  logic              habilita,
  output logic              zero
);

  logic [CONT_W-1:0] cont_q;
  logic [CONT_W-1:0] cont_d;

  // Load has priority over decrement; the count never drops below zero and otherwise holds.
  always_comb begin
    cont_d = cont_q;
    if (carregar) begin
      cont_d = valor;
    end else if (habilita && (cont_q != '0)) begin
      cont_d = cont_q - CONT_W'(1);
    end
  end

  // Count register with synchronous reset to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign zero = (cont_q == '0);

endmodule

// File: rtl/controlador_irrigacao.sv
// Irrigation controller: watering/pause FSM, completed-cycle counter and Moore output decode.
module controlador_irrigacao
  import irrigacao_pkg::*;
#(
  parameter int TEMPO_REGA  = 1000,
  parameter int TEMPO_PAUSA = 500,
  parameter int CONT_W      = CONT_W_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pulso_manual,
  input  logic       solo_seco,
  input  logic       tanque_ok,
  output logic       valvula,
  output logic       bomba,
  output logic       alarme,
  output logic [1:0] estado,
  output logic [7:0] ciclos_concluidos
);

  // Timer counts down to 0 inclusive, so loading N-1 yields exactly N cycles in the state.
  localparam logic [CONT_W-1:0] VALOR_REGA  = CONT_W'(TEMPO_REGA - 1);
  localparam logic [CONT_W-1:0] VALOR_PAUSA = CONT_W'(TEMPO_PAUSA - 1);

  estado_t           estado_q, estado_d;
  logic [7:0]        ciclos_q, ciclos_d;
  logic              carregar;
  logic [CONT_W-1:0] valor;
  logic              habilita;
  logic              zero;
  logic              conta_fim;

  temporizador #(
    .CONT_W (CONT_W)
  ) u_temporizador (
    .clock    (clock),
    .reset    (reset),
    .carregar (carregar),
    .valor    (valor),
    .habilita (habilita),
    .zero     (zero)
  );

  // Next-state logic: low tank wins, then manual pulse, then dry soil, then timer expiry.
  always_comb begin
    estado_d  = estado_q;
    carregar  = 1'b0;
    valor     = '0;
    conta_fim = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (!tanque_ok) begin
          estado_d = ALARME;
        end else if (pulso_manual || solo_seco) begin
          estado_d = REGANDO;
          carregar = 1'b1;
          valor    = VALOR_REGA;
        end
      end
      REGANDO: begin
        if (!tanque_ok) begin
          estado_d = ALARME;
        end else if (pulso_manual) begin
          estado_d = PAUSA;
          carregar = 1'b1;
          valor    = VALOR_PAUSA;
        end else if (zero) begin
          estado_d  = PAUSA;
          carregar  = 1'b1;
          valor     = VALOR_PAUSA;
          conta_fim = 1'b1;
        end
      end
      PAUSA: begin
        if (!tanque_ok) begin
          estado_d = ALARME;
        end else if (zero) begin
          estado_d = OCIOSO;
        end
      end
      ALARME: begin
        if (tanque_ok && pulso_manual) begin
          estado_d = OCIOSO;
        end
      end
    endcase
  end

  assign habilita = (estado_q == REGANDO) || (estado_q == PAUSA);

  // Only a natural timer expiry counts as a completed irrigation; 8-bit wrap is intended.
  always_comb begin
    ciclos_d = ciclos_q;
    if (conta_fim) begin
      ciclos_d = ciclos_q + 8'd1;
    end
  end

  // State and counter registers; reset closes the valve at once without passing through PAUSA.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      ciclos_q <= 8'd0;
    end else begin
      estado_q <= estado_d;
      ciclos_q <= ciclos_d;
    end
  end

  assign valvula           = (estado_q == REGANDO);
  assign bomba             = (estado_q == REGANDO);
  assign alarme            = (estado_q == ALARME);
  assign estado            = estado_q;
  assign ciclos_concluidos = ciclos_q;

endmodule

// File: tb/tb_controlador_irrigacao.sv
// Scoreboard bench for controlador_irrigacao with a mode/elapsed-time reference model.
module tb_controlador_irrigacao;

  localparam int TR = 4;
  localparam int TP = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       pulso_manual = 1'b0;
  logic       solo_seco = 1'b0;
  logic       tanque_ok = 1'b1;
  logic       valvula, bomba, alarme;
  logic [1:0] estado;
  logic [7:0] ciclos_concluidos;

  controlador_irrigacao #(
    .TEMPO_REGA  (TR),
    .TEMPO_PAUSA (TP),
    .CONT_W      (8)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .pulso_manual      (pulso_manual),
    .solo_seco         (solo_seco),
    .tanque_ok         (tanque_ok),
    .valvula           (valvula),
    .bomba             (bomba),
    .alarme            (alarme),
    .estado            (estado),
    .ciclos_concluidos (ciclos_concluidos)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] est;
    logic       v;
    logic       b;
    logic       a;
    logic [7:0] cic;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model: mode (0 idle,1 watering,2 pause,3 alarm), cycles spent in mode, completions.
  int m_mode = 0;
  int m_elapsed = 0;
  int m_ciclos = 0;

  task automatic model_step(input logic r, input logic pm, input logic ss, input logic tk);
    if (r) begin
      m_mode = 0; m_elapsed = 0; m_ciclos = 0;
    end else begin
      case (m_mode)
        0: if (!tk) m_mode = 3;
           else if (pm || ss) begin m_mode = 1; m_elapsed = 0; end
        1: if (!tk) m_mode = 3;
           else if (pm) begin m_mode = 2; m_elapsed = 0; end
           else if (m_elapsed + 1 == TR) begin
             m_mode = 2; m_elapsed = 0; m_ciclos = (m_ciclos + 1) % 256;
           end else m_elapsed++;
        2: if (!tk) m_mode = 3;
           else if (m_elapsed + 1 == TP) begin m_mode = 0; m_elapsed = 0; end
           else m_elapsed++;
        default: if (tk && pm) m_mode = 0;
      endcase
    end
  endtask

  // Drive one cycle of inputs, push the expected post-edge outputs, return just after the edge.
  task automatic step(input logic r, input logic pm, input logic ss, input logic tk);
    exp_t e;
    @(negedge clock);
    reset = r; pulso_manual = pm; solo_seco = ss; tanque_ok = tk;
    model_step(r, pm, ss, tk);
    e.est = 2'(m_mode);
    e.v   = (m_mode == 1);
    e.b   = (m_mode == 1);
    e.a   = (m_mode == 3);
    e.cic = 8'(m_ciclos);
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Monitor: every cycle the DUT presents its outputs, compare against the oldest expectation.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if ({estado, valvula, bomba, alarme} !== {e.est, e.v, e.b, e.a}) begin
        bad++;
        $display("FAIL outputs t=%0t got est=%0d v=%b b=%b a=%b want est=%0d v=%b b=%b a=%b",
                 $time, estado, valvula, bomba, alarme, e.est, e.v, e.b, e.a);
      end
      total++;
      if (ciclos_concluidos !== e.cic) begin
        bad++;
        $display("FAIL ciclos t=%0t got %0d want %0d", $time, ciclos_concluidos, e.cic);
      end
    end
  end

  task automatic check(input string nome, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got %0d want %0d", nome, got, want);
    end
  endtask

  initial begin
    int nv;
    // reset
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    check("reset_estado", int'(estado), 0);

    // Scenario 1: dry-soil pulse, full watering then pause
    nv = 0;
    step(0, 0, 1, 1);
    if (valvula) nv++;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1);
      if (valvula) nv++;
    end
    check("s1_valve_cycles", nv, 4);
    check("s1_ciclos", int'(ciclos_concluidos), 1);

    // Scenario 2: manual start, manual stop two cycles in
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    check("s2_stop_estado", int'(estado), 2);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    check("s2_ciclos", int'(ciclos_concluidos), 1);

    // Scenario 3: tank goes low while watering
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("s3_alarme", int'(alarme), 1);
    step(0, 1, 0, 0);
    check("s3_pulse_low_tank", int'(estado), 3);
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    check("s3_recover", int'(estado), 0);

    // Scenario 4: reset in the middle of watering
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    check("s4_estado", int'(estado), 0);
    check("s4_valvula", int'(valvula), 0);
    step(0, 0, 0, 1);

    // Scenario 5: soil held dry for 256 full periods
    for (int i = 0; i < 256 * (1 + TR + TP); i++) step(0, 0, 1, 1);
    check("s5_wrap", int'(ciclos_concluidos), 0);
    check("s5_estado", int'(estado), 0);
    step(0, 0, 0, 1);

    // Scenario 6: manual stop on the last watering cycle
    step(0, 0, 1, 1);
    for (int i = 0; i < TR - 1; i++) step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    check("s6_estado", int'(estado), 2);
    check("s6_ciclos", int'(ciclos_concluidos), 0);
    for (int i = 0; i < TP + 1; i++) step(0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 64) == 0, ($urandom % 8) == 0, ($urandom % 4) == 0,
           ($urandom % 16) != 0);
    end

    // Bounded drain of the scoreboard
    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clock);
    #2;
    check("scoreboard_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
